// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO unit: op encodings, FSM states and default width.
package hilo_pkg;

    localparam int HILO_DW = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4,
        OP_MFHI  = 3'd5,
        OP_MFLO  = 3'd6
    } hilo_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with multiplier issue/capture and EX stall interlock.
// Optional macro HILO_BYPASS_EN forwards the product to MFHI/MFLO in the capture cycle.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DW       = HILO_DW,
    parameter int MULT_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [DW-1:0]   rs_val,
    input  logic [DW-1:0]   rt_val,
    output logic            stall,
    output logic [DW-1:0]   rd_data,
    output logic            busy,
    output logic            mult_start,
    output logic            mult_is_signed,
    output logic [DW-1:0]   mult_a,
    output logic [DW-1:0]   mult_b,
    input  logic [2*DW-1:0] mult_s
);

    localparam int CW = $clog2(MULT_LAT + 1);

    hilo_state_t   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [DW-1:0] hi, hi_d, lo, lo_d;
    logic [DW-1:0] a_d, b_d;
    logic          start_d, signed_d;
    logic          is_mul, is_mf, is_cls;
    logic          cap, fwd, accept;

    always_comb begin
        is_mul = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
        is_mf  = (ex_op == OP_MFHI) || (ex_op == OP_MFLO);
        is_cls = is_mul || is_mf || (ex_op == OP_MTHI) || (ex_op == OP_MTLO);
    end

    // Capture cycle: the product on mult_s is valid and is written at the coming edge.
    assign cap = (state == BUSY) && (cnt == '0);

`ifdef HILO_BYPASS_EN
    assign fwd = cap;
`else
    assign fwd = 1'b0;
`endif

    assign stall  = ex_valid && (state == BUSY) && is_cls && !(fwd && is_mf);
    assign accept = ex_valid && !stall;
    assign busy   = (state == BUSY);

    always_comb begin
        rd_data = '0;
        if (accept && (ex_op == OP_MFHI)) begin
            rd_data = fwd ? mult_s[2*DW-1:DW] : hi;
        end else if (accept && (ex_op == OP_MFLO)) begin
            rd_data = fwd ? mult_s[DW-1:0] : lo;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hi_d     = hi;
        lo_d     = lo;
        start_d  = 1'b0;
        signed_d = mult_is_signed;
        a_d      = mult_a;
        b_d      = mult_b;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (ex_op)
                        OP_MULT, OP_MULTU: begin
                            a_d      = rs_val;
                            b_d      = rt_val;
                            signed_d = (ex_op == OP_MULT);
                            start_d  = 1'b1;
                            cnt_d    = CW'(MULT_LAT);
                            state_d  = BUSY;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    hi_d    = mult_s[2*DW-1:DW];
                    lo_d    = mult_s[DW-1:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset also drops any product still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            mult_start     <= 1'b0;
            mult_is_signed <= 1'b0;
            mult_a         <= '0;
            mult_b         <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            hi             <= hi_d;
            lo             <= lo_d;
            mult_start     <= start_d;
            mult_is_signed <= signed_d;
            mult_a         <= a_d;
            mult_b         <= b_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit with a one-cycle-latency multiplier model.
module tb_hilo_unit;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [2:0]      ex_op;
    logic [DW-1:0]   rs_val;
    logic [DW-1:0]   rt_val;
    logic            stall;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            mult_start;
    logic            mult_is_signed;
    logic [DW-1:0]   mult_a;
    logic [DW-1:0]   mult_b;
    logic [2*DW-1:0] mult_s;
    logic [63:0]     prod = '0;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, MTHI = 3'd3,
                           MTLO = 3'd4, MFHI = 3'd5, MFLO = 3'd6;

    hilo_unit #(.DW(DW), .MULT_LAT(1)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_data(rd_data),
        .busy(busy), .mult_start(mult_start), .mult_is_signed(mult_is_signed),
        .mult_a(mult_a), .mult_b(mult_b), .mult_s(mult_s)
    );

    always #5 clk = ~clk;

    // Multiplier model: samples start at an edge, product valid from the next cycle.
    always @(posedge clk) begin
        if (mult_start) begin
            logic [63:0] sa, sb;
            sa = mult_is_signed ? {{32{mult_a[31]}}, mult_a} : {32'b0, mult_a};
            sb = mult_is_signed ? {{32{mult_b[31]}}, mult_b} : {32'b0, mult_b};
            prod <= sa * sb;
        end
    end
    assign mult_s = prod;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        ex_valid = v;
        ex_op    = op;
        rs_val   = rs;
        rt_val   = rt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, NOP, 0, 0);
        tick();
        total++; if (busy !== 1'b0 || mult_start !== 1'b0) $display("FAIL reset_ctrl busy=%b start=%b required 0/0", busy, mult_start); else passed++;
        total++; if (mult_a !== '0 || mult_b !== '0 || mult_is_signed !== 1'b0) $display("FAIL reset_ops a=%h b=%h s=%b required 0", mult_a, mult_b, mult_is_signed); else passed++;
        rst = 1'b0;
        tick();
        drive(1'b1, MFHI, 0, 0);
        total++; if (rd_data !== 32'h0) $display("FAIL reset_hi rd=%h required 0", rd_data); else passed++;
        // Load HI/LO, start a multiply and reset in the middle of it.
        tick(); drive(1'b1, MTHI, 32'hDEADBEEF, 0);
        tick(); drive(1'b1, MTLO, 32'h00005555, 0);
        tick(); drive(1'b1, MULT, 32'd7, 32'd9);
        tick(); drive(1'b0, NOP, 0, 0);
        total++; if (busy !== 1'b1 || mult_start !== 1'b1) $display("FAIL reset_pre busy=%b start=%b required 1/1", busy, mult_start); else passed++;
        #2 rst = 1'b1;
        drive(1'b1, MFHI, 0, 0);
        total++; if (busy !== 1'b0 || mult_start !== 1'b0) $display("FAIL reset_async busy=%b start=%b required 0/0", busy, mult_start); else passed++;
        total++; if (rd_data !== 32'h0 || stall !== 1'b0) $display("FAIL reset_async_hi rd=%h stall=%b required 0/0", rd_data, stall); else passed++;
        tick();
        rst = 1'b0;
        drive(1'b0, NOP, 0, 0);
        tick(); tick(); tick();
        drive(1'b1, MFHI, 0, 0);
        total++; if (rd_data !== 32'h0) $display("FAIL reset_no_write_hi rd=%h required 0", rd_data); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (rd_data !== 32'h0) $display("FAIL reset_no_write_lo rd=%h required 0", rd_data); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_mult_signed();
        drive(1'b1, MULT, 32'hFFFFFFFF, 32'h00000002);
        total++; if (stall !== 1'b0) $display("FAIL mult_accept stall=%b required 0", stall); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
        total++; if (mult_start !== 1'b1 || mult_is_signed !== 1'b1 || busy !== 1'b1) $display("FAIL mult_issue start=%b signed=%b busy=%b required 1/1/1", mult_start, mult_is_signed, busy); else passed++;
        total++; if (mult_a !== 32'hFFFFFFFF || mult_b !== 32'h2) $display("FAIL mult_ops a=%h b=%h required ffffffff/2", mult_a, mult_b); else passed++;
        tick();
        total++; if (mult_start !== 1'b0 || busy !== 1'b1) $display("FAIL mult_a2 start=%b busy=%b required 0/1", mult_start, busy); else passed++;
        tick(); drive(1'b1, MFHI, 0, 0);
        total++; if (busy !== 1'b0 || stall !== 1'b0 || rd_data !== 32'hFFFFFFFF) $display("FAIL mult_hi busy=%b stall=%b rd=%h required 0/0/ffffffff", busy, stall, rd_data); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (rd_data !== 32'hFFFFFFFE) $display("FAIL mult_lo rd=%h required fffffffe", rd_data); else passed++;
        total++; if (mult_a !== 32'hFFFFFFFF || mult_is_signed !== 1'b1) $display("FAIL mult_hold a=%h s=%b required ffffffff/1", mult_a, mult_is_signed); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_multu();
        drive(1'b1, MULTU, 32'hFFFFFFFF, 32'h00000002);
        tick(); drive(1'b0, NOP, 0, 0);
        total++; if (mult_is_signed !== 1'b0 || mult_start !== 1'b1) $display("FAIL multu_issue signed=%b start=%b required 0/1", mult_is_signed, mult_start); else passed++;
        tick(); tick(); drive(1'b1, MFHI, 0, 0);
        total++; if (rd_data !== 32'h00000001) $display("FAIL multu_hi rd=%h required 00000001", rd_data); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (rd_data !== 32'hFFFFFFFE) $display("FAIL multu_lo rd=%h required fffffffe", rd_data); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_mflo_interlock();
        drive(1'b1, MULT, 32'hFFFFFFFF, 32'h00000002);
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (stall !== 1'b1) $display("FAIL mflo_a1 stall=%b required 1", stall); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
`ifdef HILO_BYPASS_EN
        total++; if (stall !== 1'b0 || rd_data !== 32'hFFFFFFFE) $display("FAIL mflo_bypass stall=%b rd=%h required 0/fffffffe", stall, rd_data); else passed++;
`else
        total++; if (stall !== 1'b1) $display("FAIL mflo_a2 stall=%b required 1", stall); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (stall !== 1'b0 || rd_data !== 32'hFFFFFFFE) $display("FAIL mflo_a3 stall=%b rd=%h required 0/fffffffe", stall, rd_data); else passed++;
`endif
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_mt_mf();
        drive(1'b1, MTHI, 32'h12345678, 0);
        total++; if (stall !== 1'b0) $display("FAIL mthi_stall stall=%b required 0", stall); else passed++;
        tick(); drive(1'b1, MTLO, 32'h9ABCDEF0, 0);
        total++; if (stall !== 1'b0) $display("FAIL mtlo_stall stall=%b required 0", stall); else passed++;
        tick(); drive(1'b1, MFHI, 0, 0);
        total++; if (stall !== 1'b0 || rd_data !== 32'h12345678) $display("FAIL mfhi_val stall=%b rd=%h required 0/12345678", stall, rd_data); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (stall !== 1'b0 || rd_data !== 32'h9ABCDEF0) $display("FAIL mflo_val stall=%b rd=%h required 0/9abcdef0", stall, rd_data); else passed++;
        tick(); drive(1'b1, NOP, 32'hFFFFFFFF, 0);
        total++; if (rd_data !== 32'h0) $display("FAIL nop_rd rd=%h required 0", rd_data); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_nop_busy();
        drive(1'b1, MULT, 32'd3, 32'd5);
        tick(); drive(1'b1, NOP, 0, 0);
        total++; if (stall !== 1'b0) $display("FAIL nop_busy stall=%b required 0", stall); else passed++;
        drive(1'b1, 3'd7, 0, 0);
        total++; if (stall !== 1'b0) $display("FAIL op7_busy stall=%b required 0", stall); else passed++;
        drive(1'b1, MTHI, 32'hAAAA5555, 0);
        total++; if (stall !== 1'b1) $display("FAIL mthi_busy stall=%b required 1", stall); else passed++;
        drive(1'b0, MTHI, 32'hAAAA5555, 0);
        total++; if (stall !== 1'b0) $display("FAIL invalid_busy stall=%b required 0", stall); else passed++;
        tick(); tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (rd_data !== 32'd15) $display("FAIL mid_lo rd=%h required 0000000f", rd_data); else passed++;
        tick(); drive(1'b1, MFHI, 0, 0);
        total++; if (rd_data !== 32'd0) $display("FAIL mid_hi rd=%h required 0", rd_data); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        drive(1'b1, MULT, 32'd3, 32'd5);
        tick(); drive(1'b1, MULTU, 32'h00010000, 32'h00010000);
        for (int i = 0; i < 10 && stall; i++) begin
            stalls++;
            tick(); drive(1'b1, MULTU, 32'h00010000, 32'h00010000);
        end
        total++; if (stalls !== 2) $display("FAIL b2b_stalls got=%0d required 2", stalls); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
        total++; if (mult_start !== 1'b1 || mult_is_signed !== 1'b0 || mult_a !== 32'h00010000) $display("FAIL b2b_issue start=%b s=%b a=%h required 1/0/00010000", mult_start, mult_is_signed, mult_a); else passed++;
        tick(); tick(); drive(1'b1, MFHI, 0, 0);
        total++; if (busy !== 1'b0 || rd_data !== 32'h00000001) $display("FAIL b2b_hi busy=%b rd=%h required 0/00000001", busy, rd_data); else passed++;
        tick(); drive(1'b1, MFLO, 0, 0);
        total++; if (rd_data !== 32'h00000000) $display("FAIL b2b_lo rd=%h required 0", rd_data); else passed++;
        tick(); drive(1'b0, NOP, 0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        ex_valid = 1'b0;
        ex_op    = NOP;
        rs_val   = '0;
        rt_val   = '0;
        test_reset();
        test_mult_signed();
        test_multu();
        test_mflo_interlock();
        test_mt_mf();
        test_nop_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
